// File: rtl/priority_address_encoder_pkg.sv
// Shared types and helpers for the priority address encoder.
// Optional round-robin selection is enabled by PRIORITY_ENCODER_ROUND_ROBIN_EN.
package priority_address_encoder_pkg;

   localparam int unsigned N_IN_DEFAULT = 4;

   // Helpers search a zero-extended vector of this fixed width, so N_IN must not exceed it.
   localparam int unsigned FFS_MAX_W = 64;
   localparam int unsigned FFS_IDX_W = $clog2(FFS_MAX_W);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_e;

   typedef struct packed {
      logic                 found;
      logic [FFS_IDX_W-1:0] idx;
   } ffs_t;

   // Lowest set bit index; scanning downwards lets the lowest hit win.
   function automatic ffs_t lsb_index(input logic [FFS_MAX_W-1:0] vec);
      ffs_t r;
      r = '0;
      for (int i = FFS_MAX_W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            r.found = 1'b1;
            r.idx   = FFS_IDX_W'(i);
         end
      end
      return r;
   endfunction

   function automatic logic is_one_hot(input logic [FFS_MAX_W-1:0] vec);
      return (vec != '0) && ((vec & (vec - FFS_MAX_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/priority_address_encoder_find_first_set.sv
// Combinational search for the first set bit at or after a start index, wrapping.
module priority_address_encoder_find_first_set
   import priority_address_encoder_pkg::*;
#(
   parameter  int unsigned N_IN   = N_IN_DEFAULT,
   localparam int unsigned ADDR_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]   vec,
   input  logic [ADDR_W-1:0] start,
   output logic [ADDR_W-1:0] index_c,
   output logic              found_c
);

   logic [N_IN-1:0] rotated;
   ffs_t            res;

   // Rotate so bit 'start' lands at position 0; N_IN is a power of two so the sum wraps.
   always_comb begin
      rotated = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         rotated[i] = vec[ADDR_W'(i) + start];
      end
   end

   always_comb begin
      res     = lsb_index(FFS_MAX_W'(rotated));
      found_c = res.found;
      index_c = ADDR_W'(res.idx + FFS_IDX_W'(start));
   end

endmodule

// File: rtl/priority_address_encoder.sv
// Serializes a captured multi-hot request vector into one binary address per handshake.
// Define PRIORITY_ENCODER_ROUND_ROBIN_EN for rotating (round-robin) selection.
module priority_address_encoder
   import priority_address_encoder_pkg::*;
#(
   parameter  int unsigned N_IN   = N_IN_DEFAULT,
   localparam int unsigned ADDR_W = $clog2(N_IN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [N_IN-1:0]   req_in,
   input  logic              req_load,
   output logic              load_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] address,
   output logic              out_last,
   output logic [N_IN-1:0]   pending
);

   state_e            state_q;
   state_e            state_next;
   logic [N_IN-1:0]   pending_next;
   logic [ADDR_W-1:0] start;
   logic [ADDR_W-1:0] sel_index;
   logic              sel_found;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_next;
   assign start = ptr_next;
`else
   assign start = '0;
`endif

   // Selection looks at next-cycle state so address/out_last can be registered.
   priority_address_encoder_find_first_set #(.N_IN(N_IN)) u_ffs (
      .vec     (pending_next),
      .start   (start),
      .index_c (sel_index),
      .found_c (sel_found)
   );

   always_comb begin
      state_next   = state_q;
      pending_next = pending;
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
      ptr_next     = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_load) begin
               pending_next = req_in & {N_IN{enable}};
               if (pending_next != '0) state_next = SERVE;
            end
         end
         SERVE: begin
            if (out_ready) begin
               pending_next = pending & ~(N_IN'(1) << address);
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
               ptr_next     = address + ADDR_W'(1);
`endif
               if (out_last) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pending    <= '0;
         out_valid  <= 1'b0;
         load_ready <= 1'b1;
         address    <= '0;
         out_last   <= 1'b0;
      end else begin
         state_q    <= state_next;
         pending    <= pending_next;
         out_valid  <= (state_next == SERVE);
         load_ready <= (state_next == IDLE);
         address    <= sel_found ? sel_index : '0;
         out_last   <= is_one_hot(FFS_MAX_W'(pending_next));
      end
   end

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
   // Pointer survives across bursts; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_next;
   end
`endif

endmodule

// File: tb/tb_priority_address_encoder.sv
// Randomized and directed bench for priority_address_encoder against a cycle-level reference model.
module tb_priority_address_encoder;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 2;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic [N-1:0]  req_in;
   logic          req_load;
   logic          load_ready;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] address;
   logic          out_last;
   logic [N-1:0]  pending;

   priority_address_encoder #(.N_IN(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .req_in     (req_in),
      .req_load   (req_load),
      .load_ready (load_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .address    (address),
      .out_last   (out_last),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: serving flag, set of outstanding request indices, rotating start point.
   bit     m_serve = 1'b0;
   bit     m_req[N];
   int     m_ptr   = 0;
   int     obs_log[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_req[i]) c++;
      return c;
   endfunction

   function automatic int m_vec();
      int v = 0;
      for (int i = 0; i < N; i++) if (m_req[i]) v += (1 << i);
      return v;
   endfunction

   // Walk from the pointer around the ring and take the first outstanding request.
   function automatic int m_addr();
      for (int k = 0; k < N; k++) begin
         int i = (m_ptr + k) % N;
         if (m_req[i]) return i;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_serve = 1'b0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_req[i] = 1'b0;
   endtask

   // Compare outputs, drive one cycle of inputs, advance the model, move to the next sample point.
   task automatic step(input logic en, input logic [N-1:0] req, input logic ld, input logic rdy);
      int a;
      check("out_valid", 32'(out_valid), 32'(m_serve));
      check("load_ready", 32'(load_ready), 32'(!m_serve));
      check("pending", 32'(pending), 32'(m_vec()));
      if (m_serve) begin
         check("address", 32'(address), 32'(m_addr()));
         check("out_last", 32'(out_last), 32'(m_count() == 1));
      end
      if (out_valid && rdy) obs_log.push_back(int'(address));
      enable   = en;
      req_in   = req;
      req_load = ld;
      out_ready = rdy;
      if (!m_serve) begin
         if (ld && en) begin
            for (int i = 0; i < N; i++) m_req[i] = req[i];
            m_serve = (m_count() != 0);
         end
      end else if (rdy) begin
         a = m_addr();
         m_req[a] = 1'b0;
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
         m_ptr = (a + 1) % N;
`endif
         if (m_count() == 0) m_serve = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * N + 2 && m_serve; i++) step(1'b0, '0, 1'b0, 1'b1);
      if (m_serve) check("drain_timeout", 32'(1), 32'(0));
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic burst(input logic [N-1:0] v);
      obs_log.delete();
      step(1'b1, v, 1'b1, 1'b1);
      drain();
   endtask

   task automatic check_seq(input string tag, input int e0, input int e1, input int e2, input int e3, input int len);
      int e[4];
      e = '{e0, e1, e2, e3};
      check({tag, "_len"}, 32'(obs_log.size()), 32'(len));
      for (int i = 0; i < len && i < obs_log.size(); i++)
         check({tag, "_addr"}, 32'(obs_log[i]), 32'(e[i]));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b0; req_in = '0; req_load = 1'b0; out_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_load_ready", 32'(load_ready), 32'(1));
      check("rst_pending", 32'(pending), 32'(0));
      check("rst_address", 32'(address), 32'(0));
      check("rst_out_last", 32'(out_last), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 1'b0; req_in = '0; req_load = 1'b0; out_ready = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Single request
      step(1'b1, 4'b0100, 1'b1, 1'b1);
      check("single_addr", 32'(address), 32'(2));
      check("single_last", 32'(out_last), 32'(1));
      step(1'b0, '0, 1'b0, 1'b1);
      check("single_idle_ready", 32'(load_ready), 32'(1));
      step(1'b0, '0, 1'b0, 1'b0);

      // Multi-hot with a three-cycle stall
      do_reset();
      obs_log.delete();
      step(1'b1, 4'b1011, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("stall_addr", 32'(address), 32'(0));
         step(1'b1, '0, 1'b0, 1'b0);
      end
      drain();
      check_seq("multihot", 0, 1, 3, 0, 3);

      // Gating: disabled load, empty load, load during SERVE
      step(1'b0, 4'b1111, 1'b1, 1'b1);
      check("gated_valid", 32'(out_valid), 32'(0));
      step(1'b1, 4'b0000, 1'b1, 1'b1);
      check("zero_load_ready", 32'(load_ready), 32'(1));
      step(1'b1, 4'b0011, 1'b1, 1'b0);
      step(1'b1, 4'b1111, 1'b1, 1'b0);
      check("serve_load_ignored", 32'(pending), 32'(4'b0011));
      drain();

      // Reset mid-burst
      do_reset();
      step(1'b1, 4'b1111, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'(0));
      check("midrst_pending", 32'(pending), 32'(0));
      do_reset();
      step(1'b1, 4'b0010, 1'b1, 1'b1);
      check("after_rst_addr", 32'(address), 32'(1));
      drain();

      // Ordering across bursts depends on the selection policy
      do_reset();
      burst(4'b1111);
      check_seq("allones", 0, 1, 2, 3, 4);
      burst(4'b1111);
      check_seq("allones_again", 0, 1, 2, 3, 4);
      burst(4'b0001);
      burst(4'b1001);
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
      check_seq("rr_1001", 3, 0, 0, 0, 2);
      do_reset();
      obs_log.delete();
      step(1'b1, 4'b1111, 1'b1, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      drain();
      burst(4'b1111);
      check_seq("rr_continue", 0, 1, 2, 3, 4);
`else
      check_seq("fixed_1001", 0, 3, 0, 0, 2);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(3) != 0), N'($urandom), ($urandom_range(9) < 4), ($urandom_range(9) < 6));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
